ring_port_arbiter: RTL
======================

Name: ring_port_arbiter

Overview:
- Registered, parametrised arbiter for the router's output circuit. It sits in front of the crossbar and collects one request per input direction: LOCAL, ATCLKW, CLKW and BRIDGE, or more in wider variants.
- It grants exactly one port and holds that grant as a circuit connection until the winner releases it. It supports fixed priority (LOCAL > BRIDGE > ATCLKW > CLKW order, generalised) and round-robin modes.
- A hold-timeout watchdog forcibly tears down stuck circuits.

Parameters:
- PORTS, 4, number of requesting ports (>=2). Port 0 = LOCAL, port PORTS-1 = BRIDGE, ports 1..PORTS-2 = ring directions.
- RR_MODE, 0, 0 = fixed priority; 1 = round-robin.
- MAX_HOLD, 256, maximum cycles a grant may be held; 0 disables the watchdog.
- IDW, $clog2(PORTS), width of grant index.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- request_i  input  PORTS  per-port connection request, level.
- release_i  input  PORTS  per-port release (tail flit sent), single-cycle pulse.
- grant_o  output  PORTS  one-hot grant, registered.
- grant_valid_o  output  1  OR of grant_o, registered.
- grant_id_o  output  IDW  index of granted port; 0 when no grant.
- timeout_o  output  1  one-cycle pulse on forced release.

Behaviour:
- Reset (async assert, sync deassert by system): grant_o=0, grant_valid_o=0, grant_id_o=0, timeout_o=0, state=IDLE, hold counter=0, RR pointer=0.
- FSM has 2 states.
- IDLE: if any request_i bit is set, select winner W, load grant_o=onehot(W), grant_id_o=W, grant_valid_o=1, clear the counter, go to GRANT. Latency: request seen at edge N gives grant visible after edge N, i.e. 1 cycle.
- GRANT: grant is held regardless of request_i. Dropping the request does not release.
- Release: release_i[W]=1 ends the grant. release_i bits of non-granted ports are ignored.
- Back-to-back handoff: in the release cycle, arbitration runs on that cycle's request_i.
  - If any request is present, the next grant loads at the same edge with no idle gap; otherwise grant clears and the FSM goes to IDLE.
  - In fixed mode, the releasing port may win again.
- Fixed-priority order: 0, PORTS-1, 1, 2, ..., PORTS-2.
- Round-robin: search starts at the port after the RR pointer, ascending with wrap. The pointer is updated to W on each new grant, so the last winner becomes lowest priority.
- Watchdog (MAX_HOLD>0): the counter increments every GRANT cycle.
  - When the counter reaches MAX_HOLD-1 with no release, force release and pulse timeout_o=1 for exactly one cycle, coincident with the first cycle grant changes or drops.
  - Re-arbitration follows the same rules as a normal release. In RR mode the pointer still records the timed-out port.
  - A release and the timeout in the same cycle count as a normal release: no timeout_o.
- Counter width is $clog2(MAX_HOLD+1) and it saturates, never wraps.
- Invariants: grant_o is always one-hot or zero. grant_valid_o equals |grant_o. grant_id_o is consistent with grant_o.
- Reset asserted mid-grant clears all outputs immediately. After reset, re-arbitration starts fresh with the RR pointer at 0.
- All outputs are driven only from flops, with no combinational path from input to output.

Test Plan:
- Fixed, PORTS=4: request_i=4'b1110 in IDLE → next cycle grant_o=4'b1000, grant_id_o=3. Then release_i=4'b1000 with request_i=4'b0110 → next cycle grant_o=4'b0010.
- Hold: grant on port 2, then drop request_i=0 for 10 cycles → grant_o stays 4'b0100. release_i=4'b0001 (non-granted) → still held. release_i=4'b0100 with no requests → grant_o=0, grant_valid_o=0.
- RR mode, all four requesting continuously with release every 3 cycles → grant sequence port 1, 2, 3, 0, 1, with no idle cycle between grants.
- Watchdog, MAX_HOLD=8: grant port 0, never release → exactly 8 cycles with grant_o=4'b0001, then timeout_o=1 for 1 cycle, and the grant moves to the highest pending requester. Release on cycle 8 instead → timeout_o stays 0.
- Reset mid-grant: rst_n low asynchronously while grant_o=4'b0100 → outputs go to 0 before the next clock edge. After rst_n goes high with request_i=4'b0100 → grant_o=4'b0100 one cycle later.
- Random requests/releases for 10k cycles, PORTS=6, both modes → the one-hot invariant always holds, grant only changes on release or timeout, and no requester waits more than (PORTS-1)·MAX_HOLD cycles in RR mode.

Source files
------------

// File: rtl/ring_port_arbiter.sv
// Output-circuit arbiter: grants one requesting port and holds the connection
// until the owner releases it or the hold watchdog tears it down.
module ring_port_arbiter #(
    parameter int PORTS    = 4,
    parameter int RR_MODE  = 0,
    parameter int MAX_HOLD = 256,
    parameter int IDW      = $clog2(PORTS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PORTS-1:0] request_i,
    input  logic [PORTS-1:0] release_i,
    output logic [PORTS-1:0] grant_o,
    output logic             grant_valid_o,
    output logic [IDW-1:0]   grant_id_o,
    output logic             timeout_o
);
    localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CW-1:0] HOLD_SAT  = CW'(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state_q, state_d;
    logic [PORTS-1:0] grant_d;
    logic             valid_d;
    logic [IDW-1:0]   id_d;
    logic             timeout_d;
    logic [CW-1:0]    hold_q, hold_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;

    logic             win_found;
    logic [IDW-1:0]   win_id;
    int               cand_int;
    logic [IDW-1:0]   cand;
    logic             owner_released;
    logic             hold_expired;
    logic             end_grant;

    // Walk ports in priority order; the first requester found wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand_int  = 0;
        cand      = '0;
        for (int p = 0; p < PORTS; p++) begin
            if (RR_MODE != 0) begin
                cand_int = (int'(rr_ptr_q) + 1 + p) % PORTS;
            end else if (p == 0) begin
                cand_int = 0;
            end else if (p == 1) begin
                cand_int = PORTS - 1;
            end else begin
                cand_int = p - 1;
            end
            cand = IDW'(cand_int);
            if (!win_found && request_i[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign owner_released = release_i[grant_id_o];
    assign hold_expired   = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
    assign end_grant      = (state_q == GRANT) && (owner_released || hold_expired);

    // A release (or expiry) re-arbitrates in the same cycle so handoff has no idle gap.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_o;
        valid_d   = grant_valid_o;
        id_d      = grant_id_o;
        rr_ptr_d  = rr_ptr_q;
        timeout_d = (state_q == GRANT) && hold_expired && !owner_released;
        hold_d    = '0;
        if (state_q == GRANT) begin
            hold_d = (hold_q == HOLD_SAT) ? hold_q : hold_q + CW'(1);
        end
        if ((state_q == IDLE) || end_grant) begin
            if (win_found) begin
                state_d  = GRANT;
                grant_d  = PORTS'(1) << win_id;
                valid_d  = 1'b1;
                id_d     = win_id;
                rr_ptr_d = win_id;
                hold_d   = '0;
            end else begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
                id_d    = '0;
                hold_d  = '0;
            end
        end
    end

    // All outputs come straight from these flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            grant_o       <= '0;
            grant_valid_o <= 1'b0;
            grant_id_o    <= '0;
            timeout_o     <= 1'b0;
            hold_q        <= '0;
            rr_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            grant_o       <= grant_d;
            grant_valid_o <= valid_d;
            grant_id_o    <= id_d;
            timeout_o     <= timeout_d;
            hold_q        <= hold_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

endmodule
